char_rom_arbiter: RTL and testbench

Two-port arbiter that shares one synchronous character ROM (8-bit address, 7-bit char code, fixed read latency) between two requesters. Port 0 is the pixel-path text renderer; port 1 is a background reader such as a text scroller or debug dumper. The arbiter grants at most one read per cycle, lets the current owner hold the ROM for a bounded burst, and routes each returned code to the port that issued the read. It sits between the requesters and the ROM instance inside the VGA text overlay.

---
 rtl/char_rom_pkg.sv | 17 +
 rtl/char_rom_rsp_pipe.sv | 56 +++++
 rtl/char_rom_arbiter.sv | 96 +++++++++
 tb/tb_char_rom_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/char_rom_pkg.sv
// Shared widths, port indices and the response tag used by the character ROM arbiter.
package char_rom_pkg;

    localparam int CHAR_ADDR_W = 8;
    localparam int CHAR_CODE_W = 7;

    localparam logic PORT_PIX = 1'b0;
    localparam logic PORT_BG  = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } rom_tag_t;

    localparam int TAG_W = $bits(rom_tag_t);

endpackage

// File: rtl/char_rom_rsp_pipe.sv
// Tracks which port owns each in-flight ROM read and steers returned codes to that port.
module char_rom_rsp_pipe
    import char_rom_pkg::*;
#(
    parameter int ROM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  rom_tag_t               i_tag,
    input  logic [CHAR_CODE_W-1:0] i_rom_data,
    output logic                   o_rvalid0,
    output logic                   o_rvalid1,
    output logic [CHAR_CODE_W-1:0] o_rdata0,
    output logic [CHAR_CODE_W-1:0] o_rdata1
);

    rom_tag_t r_tag [ROM_LAT];
    rom_tag_t w_exit;

    genvar gi;
    generate
        for (gi = 0; gi < ROM_LAT; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tag[gi] <= '0;
                end else if (gi == 0) begin
                    r_tag[gi] <= i_tag;
                end else begin
                    r_tag[gi] <= r_tag[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign w_exit = r_tag[ROM_LAT-1];

    // The tag leaving the pipe lines up with the ROM output for that same read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rvalid0 <= 1'b0;
            o_rvalid1 <= 1'b0;
            o_rdata0  <= '0;
            o_rdata1  <= '0;
        end else begin
            o_rvalid0 <= w_exit.valid && (w_exit.port == PORT_PIX);
            o_rvalid1 <= w_exit.valid && (w_exit.port == PORT_BG);
            if (w_exit.valid && (w_exit.port == PORT_PIX)) begin
                o_rdata0 <= i_rom_data;
            end
            if (w_exit.valid && (w_exit.port == PORT_BG)) begin
                o_rdata1 <= i_rom_data;
            end
        end
    end

endmodule

// File: rtl/char_rom_arbiter.sv
// Shares one synchronous character ROM between the pixel-path renderer (port 0)
// and a background reader (port 1) with bounded bursts per owner.
module char_rom_arbiter
    import char_rom_pkg::*;
#(
    parameter int ROM_LAT   = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_req0,
    input  logic                   i_req1,
    input  logic [CHAR_ADDR_W-1:0] i_addr0,
    input  logic [CHAR_ADDR_W-1:0] i_addr1,
    output logic                   o_gnt0,
    output logic                   o_gnt1,
    output logic                   o_rvalid0,
    output logic                   o_rvalid1,
    output logic [CHAR_CODE_W-1:0] o_rdata0,
    output logic [CHAR_CODE_W-1:0] o_rdata1,
    output logic [CHAR_ADDR_W-1:0] o_rom_addr,
    input  logic [CHAR_CODE_W-1:0] i_rom_data
);

    localparam int                CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BURST);

    logic                   r_owner;
    logic [CNT_W-1:0]       r_burst_cnt;
    logic [CHAR_ADDR_W-1:0] r_last_addr;

    logic                   w_any_gnt;
    logic                   w_gnt_port;
    logic [CHAR_ADDR_W-1:0] w_gnt_addr;
    rom_tag_t               w_push_tag;

    // Grant depends only on requests and registered state, never on ROM data.
    always_comb begin
        w_any_gnt  = 1'b0;
        w_gnt_port = r_owner;
        if (rst_n) begin
            if (i_req0 && i_req1) begin
                w_any_gnt  = 1'b1;
                w_gnt_port = (r_burst_cnt < MAX_CNT) ? r_owner : ~r_owner;
            end else if (i_req0) begin
                w_any_gnt  = 1'b1;
                w_gnt_port = PORT_PIX;
            end else if (i_req1) begin
                w_any_gnt  = 1'b1;
                w_gnt_port = PORT_BG;
            end
        end
    end

    assign o_gnt0     = w_any_gnt && (w_gnt_port == PORT_PIX);
    assign o_gnt1     = w_any_gnt && (w_gnt_port == PORT_BG);
    assign w_gnt_addr = (w_gnt_port == PORT_BG) ? i_addr1 : i_addr0;
    assign o_rom_addr = w_any_gnt ? w_gnt_addr : r_last_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= PORT_PIX;
            r_burst_cnt <= '0;
            r_last_addr <= '0;
        end else if (!w_any_gnt) begin
            r_burst_cnt <= '0;
        end else begin
            r_last_addr <= w_gnt_addr;
            if (w_gnt_port == r_owner) begin
                if (r_burst_cnt < MAX_CNT) begin
                    r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                end
            end else begin
                r_owner     <= w_gnt_port;
                r_burst_cnt <= CNT_W'(1);
            end
        end
    end

    assign w_push_tag.valid = w_any_gnt;
    assign w_push_tag.port  = w_gnt_port;

    char_rom_rsp_pipe #(
        .ROM_LAT (ROM_LAT)
    ) u_rsp_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tag      (w_push_tag),
        .i_rom_data (i_rom_data),
        .o_rvalid0  (o_rvalid0),
        .o_rvalid1  (o_rvalid1),
        .o_rdata0   (o_rdata0),
        .o_rdata1   (o_rdata1)
    );

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Drives two arbiters (MAX_BURST=4 and MAX_BURST=1) with identical requests and
// scoreboards grants, ROM addresses and returned codes against a reference model.
module tb_char_rom_arbiter;

    localparam int LAT = 1;

    typedef struct {
        logic [6:0] data;
        int         due;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] addr0, addr1;

    logic [1:0] gnt0_v, gnt1_v, rvalid0_v, rvalid1_v;
    logic [6:0] rdata0_v [2];
    logic [6:0] rdata1_v [2];
    logic [7:0] rom_addr_v [2];
    logic [6:0] rom_data_v [2];

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    exp_t sb_q [4][$];

    int         owner_m [2];
    int         cnt_m   [2];
    logic [7:0] last_m  [2];
    logic [6:0] held_m  [4];

    char_rom_arbiter #(.ROM_LAT(LAT), .MAX_BURST(4)) u_dut_b4 (
        .clk(clk), .rst_n(rst_n), .i_req0(req0), .i_req1(req1),
        .i_addr0(addr0), .i_addr1(addr1),
        .o_gnt0(gnt0_v[0]), .o_gnt1(gnt1_v[0]),
        .o_rvalid0(rvalid0_v[0]), .o_rvalid1(rvalid1_v[0]),
        .o_rdata0(rdata0_v[0]), .o_rdata1(rdata1_v[0]),
        .o_rom_addr(rom_addr_v[0]), .i_rom_data(rom_data_v[0])
    );

    char_rom_arbiter #(.ROM_LAT(LAT), .MAX_BURST(1)) u_dut_b1 (
        .clk(clk), .rst_n(rst_n), .i_req0(req0), .i_req1(req1),
        .i_addr0(addr0), .i_addr1(addr1),
        .o_gnt0(gnt0_v[1]), .o_gnt1(gnt1_v[1]),
        .o_rvalid0(rvalid0_v[1]), .o_rvalid1(rvalid1_v[1]),
        .o_rdata0(rdata0_v[1]), .o_rdata1(rdata1_v[1]),
        .o_rom_addr(rom_addr_v[1]), .i_rom_data(rom_data_v[1])
    );

    // Team character ROM contents for the addresses used by name; the rest is filler.
    function automatic logic [6:0] rom_fn(input logic [7:0] a);
        case (a)
            8'h00:   return 7'h4a;
            8'h01:   return 7'h65;
            8'h08:   return 7'h50;
            8'h5f:   return 7'h79;
            default: return 7'(a ^ (a >> 3)) ^ 7'h11;
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        rom_data_v[0] <= rom_fn(rom_addr_v[0]);
        rom_data_v[1] <= rom_fn(rom_addr_v[1]);
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            int         mb;
            int         g;
            int         q;
            logic       exp_v;
            logic       got_v;
            logic [6:0] got_d;
            logic [7:0] exp_addr;
            exp_t       e;
            mb = (d == 0) ? 4 : 1;
            if (!rst_n) begin
                check_val($sformatf("d%0d_rst_gnt", d), {gnt1_v[d], gnt0_v[d]}, 0);
                check_val($sformatf("d%0d_rst_rvalid", d), {rvalid1_v[d], rvalid0_v[d]}, 0);
                check_val($sformatf("d%0d_rst_rdata0", d), rdata0_v[d], 0);
                check_val($sformatf("d%0d_rst_rdata1", d), rdata1_v[d], 0);
                check_val($sformatf("d%0d_rst_rom_addr", d), rom_addr_v[d], 0);
                owner_m[d] = 0;
                cnt_m[d]   = 0;
                last_m[d]  = 8'h00;
                for (int p = 0; p < 2; p++) begin
                    sb_q[d*2+p].delete();
                    held_m[d*2+p] = 7'h00;
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    q     = d * 2 + p;
                    exp_v = (sb_q[q].size() > 0) && (sb_q[q][0].due == cyc);
                    got_v = (p == 0) ? rvalid0_v[d] : rvalid1_v[d];
                    got_d = (p == 0) ? rdata0_v[d] : rdata1_v[d];
                    check_val($sformatf("d%0d_rvalid%0d", d, p), got_v, exp_v);
                    if (exp_v) begin
                        held_m[q] = sb_q[q][0].data;
                        void'(sb_q[q].pop_front());
                        $display("cyc=%0d dut%0d port%0d rvalid data=%0h", cyc, d, p, got_d);
                    end
                    check_val($sformatf("d%0d_rdata%0d", d, p), got_d, held_m[q]);
                end

                g = -1;
                if (req0 && req1) g = (cnt_m[d] < mb) ? owner_m[d] : 1 - owner_m[d];
                else if (req0)    g = 0;
                else if (req1)    g = 1;

                exp_addr = (g == 0) ? addr0 : (g == 1) ? addr1 : last_m[d];
                check_val($sformatf("d%0d_gnt0", d), gnt0_v[d], (g == 0) ? 1 : 0);
                check_val($sformatf("d%0d_gnt1", d), gnt1_v[d], (g == 1) ? 1 : 0);
                check_val($sformatf("d%0d_rom_addr", d), rom_addr_v[d], exp_addr);

                if (g < 0) begin
                    cnt_m[d] = 0;
                end else begin
                    last_m[d] = exp_addr;
                    if (g == owner_m[d]) begin
                        if (cnt_m[d] < mb) cnt_m[d] = cnt_m[d] + 1;
                    end else begin
                        owner_m[d] = g;
                        cnt_m[d]   = 1;
                    end
                    e.data = rom_fn(exp_addr);
                    e.due  = cyc + LAT + 1;
                    sb_q[d*2+g].push_back(e);
                    $display("cyc=%0d dut%0d grant port%0d addr=%0h", cyc, d, g, exp_addr);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic [7:0] a0, input logic r1, input logic [7:0] a1);
        req0  = r0;
        addr0 = a0;
        req1  = r1;
        addr1 = a1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        #1 rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);

        // single port read
        drive(1'b1, 8'h00, 1'b0, 8'h00);
        step(1);
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        step(4);

        // sustained contention
        drive(1'b1, 8'h01, 1'b1, 8'h08);
        step(20);
        drive(1'b0, 8'h01, 1'b0, 8'h08);
        step(4);

        // burst break by an idle cycle
        drive(1'b1, 8'h01, 1'b0, 8'h08);
        step(3);
        drive(1'b0, 8'h01, 1'b0, 8'h08);
        step(1);
        drive(1'b1, 8'h01, 1'b1, 8'h08);
        step(10);
        drive(1'b0, 8'h01, 1'b0, 8'h08);
        step(4);

        // address hold after a lone port-1 read
        drive(1'b0, 8'h00, 1'b1, 8'h5f);
        step(1);
        drive(1'b0, 8'h33, 1'b0, 8'h44);
        step(5);

        // randomised requests
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
            step(1);
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        step(4);

        // reset in the cycle after a port-0 grant
        drive(1'b1, 8'h01, 1'b0, 8'h00);
        step(1);
        drive(1'b0, 8'h01, 1'b0, 8'h00);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 8'h08);
        step(1);
        drive(1'b0, 8'h00, 1'b0, 8'h08);
        step(6);

        for (int q = 0; q < 4; q++) begin
            check_val($sformatf("sb_drain%0d", q), sb_q[q].size(), 0);
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
